// File: rtl/node_pkg.sv
// node_pkg -- shared types and constants for the node chain.
//   q16_t        : signed two's-complement Q16.16 coordinate
//   Q16_MAX/MIN  : saturation rails
//   DEF_*        : default parameter values for node
//   sat34()      : saturate a wide sum back into q16_t
package node_pkg;

  typedef logic signed [31:0] q16_t;

  localparam q16_t Q16_MAX = 32'sh7FFF_FFFF;
  localparam q16_t Q16_MIN = 32'sh8000_0000;

  localparam q16_t DEF_INIT_SPACING = 32'sh000A_0000;  // 10.0
  localparam q16_t DEF_MAX_STEP     = 32'sh0004_0000;  // 4.0
  localparam q16_t DEF_GRAVITY      = 32'sh0000_4000;  // 0.25

  // Sums of a q16 and a clamped 33-bit delta always fit in 34 bits.
  function automatic q16_t sat34(input logic signed [33:0] v);
    if (v > 34'sh0_7FFF_FFFF)       return Q16_MAX;
    else if (v < -34'sh0_8000_0000) return Q16_MIN;
    else                            return q16_t'(v[31:0]);
  endfunction

endpackage

// File: rtl/node_step.sv
// node_step -- combinational clamp-and-add for one axis.
//   pos   : current coordinate (q16)
//   delta : requested move, 33-bit signed so target-pos never wraps
//   limit : positive magnitude bound for delta
//   sum   : sat(pos + clamp(delta, -limit, +limit))
module node_step
  import node_pkg::*;
(
  input  q16_t               pos,
  input  logic signed [32:0] delta,
  input  q16_t               limit,
  output q16_t               sum
);

  logic signed [32:0] lim;
  logic signed [32:0] d_c;

  always_comb begin
    lim = 33'(limit);
    d_c = delta;
    if (delta > lim)       d_c = lim;
    else if (delta < -lim) d_c = -lim;
    sum = sat34(34'(pos) + 34'(d_c));
  end

endmodule

// File: rtl/node.sv
// node -- one link of a follow-the-leader chain, Q16.16 coordinates.
//   Head (NODE_ID==1) steps toward (x_mouse, y_mouse) on ctrl_a, each axis
//   limited to MAX_STEP. Other nodes load (new_x, new_y) on ctrl_a and,
//   when NODE_GRAVITY_EN is defined, fall by GRAVITY on ctrl_b alone.
//   ctrl_a wins over ctrl_b. All sums saturate.
// Ports:
//   clk, reset (async, active low)
//   ctrl_a, ctrl_b      : update strobes
//   new_x, new_y        : constrained candidate (non-head)
//   x_mouse, y_mouse    : target (head)
//   x_pos, y_pos        : registered position
// Config macro: NODE_GRAVITY_EN enables the ctrl_b gravity update.
module node
  import node_pkg::*;
#(
  parameter int   NODE_ID      = 1,
  parameter q16_t INIT_SPACING = DEF_INIT_SPACING,
  parameter q16_t MAX_STEP     = DEF_MAX_STEP,
  parameter q16_t GRAVITY      = DEF_GRAVITY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_a,
  input  logic        ctrl_b,
  input  logic [31:0] new_x,
  input  logic [31:0] new_y,
  input  logic [31:0] x_mouse,
  input  logic [31:0] y_mouse,
  output logic [31:0] x_pos,
  output logic [31:0] y_pos
);

  localparam bit IS_HEAD = (NODE_ID == 1);

  // Reset x is the product truncated to 32 bits.
  localparam logic [63:0] RST_PROD = 64'(NODE_ID - 1) * 64'($unsigned(INIT_SPACING));
  localparam q16_t        RST_X    = q16_t'(RST_PROD[31:0]);

  q16_t x_q, y_q;
  q16_t x_step, y_step;
  q16_t lim_y;
  logic signed [32:0] dx, dy, dy_in;

  assign x_pos = x_q;
  assign y_pos = y_q;

  // 33-bit differences: the full q16 range apart cannot overflow.
  assign dx = 33'($signed(x_mouse)) - 33'(x_q);
  assign dy = 33'($signed(y_mouse)) - 33'(y_q);

  // The y-axis step unit doubles as the gravity adder on non-head nodes.
`ifdef NODE_GRAVITY_EN
  assign dy_in = IS_HEAD ? dy : 33'(GRAVITY);
  assign lim_y = IS_HEAD ? MAX_STEP : GRAVITY;
`else
  assign dy_in = dy;
  assign lim_y = MAX_STEP;
`endif

  node_step u_step_x (.pos(x_q), .delta(dx),    .limit(MAX_STEP), .sum(x_step));
  node_step u_step_y (.pos(y_q), .delta(dy_in), .limit(lim_y),    .sum(y_step));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= RST_X;
      y_q <= '0;
    end else if (ctrl_a) begin
      if (IS_HEAD) begin
        x_q <= x_step;
        y_q <= y_step;
      end else begin
        x_q <= new_x;
        y_q <= new_y;
      end
    end
`ifdef NODE_GRAVITY_EN
    else if (ctrl_b && !IS_HEAD) begin
      y_q <= y_step;
    end
`endif
  end

endmodule

// File: tb/tb_node.sv
// tb_node -- three nodes (ids 1,2,3) sharing stimulus, checked every cycle
// against a plain-integer model of the chain rules, plus directed cases.
module tb_node;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_a, ctrl_b;
  logic [31:0] new_x, new_y, x_mouse, y_mouse;
  logic [31:0] xo[3], yo[3];

  int n_tests = 0;
  int n_fail  = 0;

  localparam longint SPACING = 64'h000A_0000;
  localparam longint MSTEP   = 64'h0004_0000;
  localparam longint GRAV    = 64'h0000_4000;
`ifdef NODE_GRAVITY_EN
  localparam bit GEN = 1'b1;
`else
  localparam bit GEN = 1'b0;
`endif

  longint mx[3], my[3];

  always #5 clk = ~clk;

  node #(.NODE_ID(1)) u_n1 (.clk(clk), .reset(reset), .ctrl_a(ctrl_a), .ctrl_b(ctrl_b),
    .new_x(new_x), .new_y(new_y), .x_mouse(x_mouse), .y_mouse(y_mouse), .x_pos(xo[0]), .y_pos(yo[0]));
  node #(.NODE_ID(2)) u_n2 (.clk(clk), .reset(reset), .ctrl_a(ctrl_a), .ctrl_b(ctrl_b),
    .new_x(new_x), .new_y(new_y), .x_mouse(x_mouse), .y_mouse(y_mouse), .x_pos(xo[1]), .y_pos(yo[1]));
  node #(.NODE_ID(3)) u_n3 (.clk(clk), .reset(reset), .ctrl_a(ctrl_a), .ctrl_b(ctrl_b),
    .new_x(new_x), .new_y(new_y), .x_mouse(x_mouse), .y_mouse(y_mouse), .x_pos(xo[2]), .y_pos(yo[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint clampd(input longint d, input longint l);
    if (d > l)  return l;
    if (d < -l) return -l;
    return d;
  endfunction

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mx[k] = sx(32'(longint'(k) * SPACING));
      my[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        if (ctrl_a) begin
          mx[k] = sat(mx[k] + clampd(sx(x_mouse) - mx[k], MSTEP));
          my[k] = sat(my[k] + clampd(sx(y_mouse) - my[k], MSTEP));
        end
      end else if (ctrl_a) begin
        mx[k] = sx(new_x);
        my[k] = sx(new_y);
      end else if (ctrl_b && GEN) begin
        my[k] = sat(my[k] + GRAV);
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.x%0d", tag, k + 1), xo[k], 32'(mx[k]));
      chk($sformatf("%s.y%0d", tag, k + 1), yo[k], 32'(my[k]));
    end
  endtask

  // Inputs already set; advance one edge and compare all nodes.
  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic drive(input logic a, input logic b, input logic [31:0] nx, input logic [31:0] ny,
                       input logic [31:0] mxi, input logic [31:0] myi);
    ctrl_a = a; ctrl_b = b; new_x = nx; new_y = ny; x_mouse = mxi; y_mouse = myi;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
      2:       return 32'h7FFF_0000 + 32'($urandom_range(0, 32'hFFFF));
      default: return 32'h8000_0000 + 32'($urandom_range(0, 32'hFFFF));
    endcase
  endfunction

  logic [31:0] exp_ramp[5];

  initial begin
    exp_ramp[0] = 32'h0004_0000; exp_ramp[1] = 32'h0008_0000; exp_ramp[2] = 32'h000C_0000;
    exp_ramp[3] = 32'h0010_0000; exp_ramp[4] = 32'h0010_0000;

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all("reset");
    chk("reset.x3_const", xo[2], 32'h0014_0000);
    @(negedge clk); reset = 1'b1;
    cyc("release");

    // Head ramp toward x=16.0
    drive(1, 0, 0, 0, 32'h0010_0000, 0);
    for (int i = 0; i < 5; i++) begin
      cyc("ramp");
      chk($sformatf("ramp%0d.x1", i), xo[0], exp_ramp[i]);
      chk($sformatf("ramp%0d.y1", i), yo[0], 32'h0);
    end

    // Non-head load
    drive(1, 0, 32'h0001_0000, 32'hFFFF_0000, 32'h0010_0000, 0);
    cyc("load");
    chk("load.x3", xo[2], 32'h0001_0000);
    chk("load.y3", yo[2], 32'hFFFF_0000);

    // Gravity saturation at the positive rail
    drive(1, 0, 0, 32'h7FFF_F000, 32'h0010_0000, 0);
    cyc("grav_pre");
    drive(0, 1, 0, 0, 0, 0);
    cyc("grav");
    chk("grav.y2", yo[1], GEN ? 32'h7FFF_FFFF : 32'h7FFF_F000);

    // Both strobes: load only
    drive(1, 1, 0, 32'h0002_0000, 0, 0);
    cyc("both");
    chk("both.y2", yo[1], 32'h0002_0000);

    // Idle holds
    drive(0, 0, $urandom, $urandom, $urandom, $urandom);
    cyc("idle");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            rnd_val(), rnd_val(), rnd_val(), rnd_val());
      cyc("rand");
    end

    // Drive head to the positive rail, then reverse with a huge target
    #2; reset = 1'b0; model_reset(); #1;
    check_all("reset2");
    @(negedge clk); reset = 1'b1;
    drive(1, 0, 0, 0, 32'h7FFF_0000, 0);
    for (int i = 0; i < 8192; i++) begin
      model_edge();
      @(posedge clk);
    end
    #1;
    check_all("rail");
    chk("rail.x1", xo[0], 32'h7FFF_0000);
    drive(1, 0, 0, 0, 32'h8000_0000, 0);
    cyc("rev");
    chk("rev.x1", xo[0], 32'h7FFB_0000);

    // Asynchronous reset mid-cycle, no clock edge between assert and check
    drive(1, 0, 0, 0, 32'h8000_0000, 0);
    @(posedge clk); #2;
    reset = 1'b0; model_reset();
    #1;
    check_all("async");
    chk("async.x1", xo[0], 32'h0);
    #1; reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    cyc("post_async");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/node.md
NODE -- requirements
Module: node

Interface
REQ-001 SHALL have parameter NODE_ID, default 1: 1-based chain position; 1 = head node.
REQ-002 SHALL have parameter INIT_SPACING, default 32'h000A_0000 (10.0): reset x spacing between nodes.
REQ-003 SHALL have parameter MAX_STEP, default 32'h0004_0000 (4.0): head per-axis step limit, positive.
REQ-004 SHALL have parameter GRAVITY, default 32'h0000_4000 (0.25): per-phase-B y increment.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port ctrl_a, input, 1 bit: phase-A update strobe, one-hot token bit.
REQ-008 SHALL have port ctrl_b, input, 1 bit: phase-B update strobe.
REQ-009 SHALL have port new_x, input, 32 bits: constrained x candidate.
REQ-010 SHALL have port new_y, input, 32 bits: constrained y candidate.
REQ-011 SHALL have port x_mouse, input, 32 bits: target x.
REQ-012 SHALL have port y_mouse, input, 32 bits: target y.
REQ-013 SHALL have port x_pos, output, 32 bits: registered x position.
REQ-014 SHALL have port y_pos, output, 32 bits: registered y position.

Function
REQ-015 All coordinates SHALL be signed two's-complement Q16.16; every sum SHALL saturate to 32'h7FFF_FFFF / 32'h8000_0000, never wrap.
REQ-016 x_pos/y_pos SHALL be driven directly from registers and SHALL change only on a rising clk edge or on reset.
REQ-017 Head (NODE_ID==1), ctrl_a=1: per axis, d = target - pos, computed in 33 bits; d SHALL be clamped to [-MAX_STEP, +MAX_STEP]; pos <= sat(pos + d).
REQ-018 Head SHALL ignore new_x/new_y and ctrl_b.
REQ-019 Non-head, ctrl_a=1: x_pos <= new_x and y_pos <= new_y, with one-cycle latency.
REQ-020 Non-head, ctrl_b=1 and ctrl_a=0: y_pos <= sat(y_pos + GRAVITY); x_pos SHALL hold (see REQ-025).
REQ-021 ctrl_a and ctrl_b both high: ctrl_a action only.
REQ-022 Both strobes low: both registers SHALL hold.
REQ-023 Non-head nodes SHALL ignore x_mouse/y_mouse.

Reset
REQ-024 While reset=0: x_pos = (NODE_ID-1)*INIT_SPACING, truncated to 32 bits; y_pos = 0. Reset SHALL apply immediately and asynchronously, including mid-update; release SHALL take effect at the next rising edge.

Configuration
REQ-025 Macro NODE_GRAVITY_EN: defined -> REQ-020 active; undefined -> ctrl_b alone SHALL hold both registers for all nodes, and GRAVITY SHALL be unused.

Structure
REQ-026 Shared package node_pkg SHALL hold the Q16.16 type (signed 32-bit), the saturation limit constants, and the default parameter constants.
REQ-027 One sub-module, node_step (combinational): inputs pos, delta, limit; it clamps delta to ±limit and returns the saturated pos+delta. It SHALL be instantiated per axis; gravity SHALL use it with limit = GRAVITY.

Verification
REQ-028 Head, x_mouse=32'h0010_0000, y_mouse=0, after reset, ctrl_a pulsed 5 cycles -> x_pos 0x0004_0000, 0x0008_0000, 0x000C_0000, 0x0010_0000, 0x0010_0000; y_pos stays 0.
REQ-029 NODE_ID=3 -> reset gives x_pos=0x0014_0000, y_pos=0; ctrl_a with new=(0x0001_0000, 0xFFFF_0000) -> next cycle x_pos=0x0001_0000, y_pos=0xFFFF_0000.
REQ-030 NODE_ID=2, NODE_GRAVITY_EN, y_pos=0x7FFF_F000, ctrl_b=1 -> y_pos=0x7FFF_FFFF; without the macro -> y_pos unchanged.
REQ-031 Non-head, ctrl_a and ctrl_b both high, new_y=0x0002_0000 -> y_pos=0x0002_0000, no gravity added.
REQ-032 Head, x_pos=0x7FFF_0000, x_mouse=0x8000_0000 -> clamped step -MAX_STEP, x_pos=0x7FFB_0000 (no overflow); reset=0 asserted mid-cycle -> outputs return to reset values before the next edge.
